// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared CPU defines for the write-back to register-file interface. The
// write-back stage packs its request with these positions and the register
// file unpacks it with the same ones:
//   wb2rf_bus = {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int WB2RF_WD    = 38;
    localparam int RF_WE_BIT   = 37;
    localparam int RF_WADDR_HI = 36;
    localparam int RF_WADDR_LO = 32;
    localparam int RF_WDATA_HI = 31;
    localparam int RF_WDATA_LO = 0;

    localparam int RF_AW = RF_WADDR_HI - RF_WADDR_LO + 1;
    localparam int RF_DW = RF_WDATA_HI - RF_WDATA_LO + 1;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    // Storage for x1..x31 only; x0 is hardwired and never stored.
    typedef logic [31:1][RF_DW-1:0] rf_array_t;

endpackage

// File: rtl/regfile_read_port.sv
// ----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file.
// Ports:
//   rst_n  in   reset, active-low; forces zero output while asserted
//   raddr  in   register index to read
//   wr_en  in   qualified write strobe (rf_we and rf_waddr != 0)
//   waddr  in   write index, compared for bypass
//   wdata  in   write data, forwarded on bypass
//   regs   in   stored x1..x31
//   rdata  out  read data
// ----------------------------------------------------------------------------
module rf_read_port
    import regfile_pkg::*;
(
    input  logic      rst_n,
    input  rf_addr_t  raddr,
    input  logic      wr_en,
    input  rf_addr_t  waddr,
    input  rf_data_t  wdata,
    input  rf_array_t regs,
    output rf_data_t  rdata
);

    always_comb begin
        rdata = '0;
        if (!rst_n || raddr == '0) begin
            rdata = '0;
        end else if (wr_en && waddr == raddr) begin
            // Write-before-read: the value being written this cycle wins.
            rdata = wdata;
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
// 31 x 32-bit architectural register file (x0 reads as zero) with two
// combinational read ports and one write port from the write-back stage.
// Ports:
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous active-low reset, clears x1..x31
//   wb2rf_bus  in   {rf_we, rf_waddr, rf_wdata}
//   raddr1/2   in   read indices
//   rdata1/2   out  read data, zero latency, bypassed from the write port
// ----------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int WB2RF_WD = regfile_pkg::WB2RF_WD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WB2RF_WD-1:0] wb2rf_bus,
    input  logic [4:0]          raddr1,
    output logic [31:0]         rdata1,
    input  logic [4:0]          raddr2,
    output logic [31:0]         rdata2
);

    logic      rf_we;
    rf_addr_t  rf_waddr;
    rf_data_t  rf_wdata;
    logic      wr_en;
    rf_array_t regs;

    assign rf_we    = wb2rf_bus[RF_WE_BIT];
    assign rf_waddr = wb2rf_bus[RF_WADDR_HI:RF_WADDR_LO];
    assign rf_wdata = wb2rf_bus[RF_WDATA_HI:RF_WDATA_LO];

    // Writes to x0 are dropped here so neither storage nor bypass sees them.
    assign wr_en = rf_we && (rf_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    rf_read_port u_rd1 (
        .rst_n (rst_n),
        .raddr (raddr1),
        .wr_en (wr_en),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .regs  (regs),
        .rdata (rdata1)
    );

    rf_read_port u_rd2 (
        .rst_n (rst_n),
        .raddr (raddr2),
        .wr_en (wr_en),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .regs  (regs),
        .rdata (rdata2)
    );

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL provide parameter WB2RF_WD, default 38, width of the write-back-to-register-file bus.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port wb2rf_bus  input  WB2RF_WD  write request {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-005 SHALL provide port raddr1  input  5  read port 1 register index.
REQ-006 SHALL provide port rdata1  output  32  read port 1 data.
REQ-007 SHALL provide port raddr2  input  5  read port 2 register index.
REQ-008 SHALL provide port rdata2  output  32  read port 2 data.

Function
REQ-009 SHALL hold 31 architectural 32-bit registers, x1..x31; x0 has no storage.
REQ-010 SHALL write rf_wdata into register rf_waddr on the rising clk edge when rf_we=1 and rf_waddr!=0.
REQ-011 SHALL ignore writes with rf_we=0 or rf_waddr=0; no register changes.
REQ-012 SHALL drive rdata1/rdata2 combinationally from raddr1/raddr2 with zero-cycle read latency.
REQ-013 SHALL return 32'h0 on any read port whose address is 0, regardless of wb2rf_bus.
REQ-014 SHALL bypass: when rf_we=1, rf_waddr!=0 and rf_waddr==raddrN, rdataN SHALL equal rf_wdata in the same cycle (write-before-read).
REQ-015 SHALL otherwise return the stored register value on rdataN.
REQ-016 SHALL evaluate both read ports independently; equal raddr1/raddr2 SHALL return identical data, bypass included.
REQ-017 SHALL accept one write per cycle; back-to-back writes to the same index SHALL leave the last-written value.
REQ-018 SHALL treat a write and a read of the same index in the same cycle as reading the new value (REQ-014), with the stored value updated at the following edge.
REQ-019 SHALL not stall or back-pressure; the block has no handshake and accepts wb2rf_bus every cycle.

Reset
REQ-020 SHALL clear x1..x31 to 32'h0 immediately on rst_n falling, independent of clk.
REQ-021 SHALL suppress all writes while rst_n=0, including the clk edge coinciding with reset release if rst_n is still low.
REQ-022 SHALL return 32'h0 on both read ports while rst_n=0 (bypass disabled in reset).
REQ-023 SHALL accept the first write on the first rising clk edge with rst_n=1.

Structure
REQ-024 SHALL take WB2RF_WD and the bus field positions (WE bit 37, WADDR 36:32, WDATA 31:0) from the shared CPU defines package used by the write-back stage.
REQ-025 SHALL implement the read path as one sub-module, rf_read_port (x0 zeroing, bypass compare, array select), instantiated twice.
REQ-026 SHALL keep the storage array and write logic in regfile itself.

Verification
REQ-027 Reset: assert rst_n=0 mid-run after x5=32'h1234 -> rdata of x5 reads 32'h0 immediately and after release.
REQ-028 Write/read: write x7=32'hDEADBEEF, next cycle raddr1=7 -> rdata1=32'hDEADBEEF; raddr2=8 -> 32'h0.
REQ-029 x0: rf_we=1, rf_waddr=0, wdata=32'hFFFFFFFF -> raddr1=0 returns 32'h0 same cycle and after.
REQ-030 Bypass: x3 holds 32'h1; same cycle write x3=32'h2 with raddr1=raddr2=3 -> both read 32'h2; after the edge, still 32'h2.
REQ-031 Disabled write: rf_we=0, rf_waddr=9, wdata=32'hA5A5A5A5 with raddr1=9 -> rdata1 keeps prior value 32'h0, no bypass.
REQ-032 Back-to-back: write x31=32'h10 then x31=32'h20 on consecutive edges -> rdata2 (raddr2=31) reads 32'h20 thereafter.
